// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule definitions.
//   - KEY_W / NR : key width and number of AES-128 rounds
//   - ks_state_t : state encoding for the inverse key schedule FSM
//   - sbox()     : AES forward S-box (same table the forward expansion uses)
//   - rcon()     : round constant word {rc, 24'h0} keyed by round number
// No ports (package).
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } ks_state_t;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  // Round constant for round rnd (1..10); the same mapping serves the
  // forward expansion (producing round rnd) and the inverse step (undoing it).
  function automatic logic [31:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword: 32-bit combinational SubWord, four parallel S-box lookups.
// Shared by the forward key expansion and the inverse key schedule.
// Ports:
//   word_in  in  32 : input word
//   word_out out 32 : S-box applied to each byte of word_in
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: iterative AES-128 inverse key schedule. Loads the
// round-10 key and emits round keys 10 down to 0, one per valid/ready
// handshake, then pulses done.
// Optional build macro: INV_KSCHED_SBOX_PIPE_EN -- inserts a SUB state that
// registers the SubWord result, so each key after the first costs 2 cycles.
// Ports:
//   clk        in   1   : clock, rising edge
//   rst_n      in   1   : synchronous active-low reset
//   start      in   1   : begin a run (only honoured while idle)
//   last_key   in 128   : round-10 key, word 0 in [127:96]
//   rk_ready   in   1   : consumer accepts round_key
//   rk_valid   out  1   : round_key / rk_idx valid
//   round_key  out 128  : current round key
//   rk_idx     out  4   : round number of round_key (10..0)
//   busy       out  1   : run in progress
//   done       out  1   : one-cycle pulse after round 0 is accepted
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] last_key,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       rk_idx,
  output logic             busy,
  output logic             done
);

  ks_state_t        state, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic [3:0]       rnd, rnd_next;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      w1n, w2n, w3n;
  logic [31:0]      sub_out;
`ifdef INV_KSCHED_SBOX_PIPE_EN
  logic [31:0]      sub_reg, sub_next;
`endif

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  // Undo the forward chaining of words 1..3; word 0 then needs the
  // recovered previous-round w3 through RotWord/SubWord.
  assign w3n = w3 ^ w2;
  assign w2n = w2 ^ w1;
  assign w1n = w1 ^ w0;

  aes_subword u_subword (
    .word_in  ({w3n[23:0], w3n[31:24]}),
    .word_out (sub_out)
  );

  assign round_key = key_reg;
  assign rk_idx    = rnd;

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    key_next   = key_reg;
    rnd_next   = rnd;
`ifdef INV_KSCHED_SBOX_PIPE_EN
    sub_next   = sub_reg;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next = EMIT;
          key_next   = last_key;
          rnd_next   = 4'(NR);
        end else begin
          state_next = IDLE;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rnd == 4'd0) begin
            state_next = DONE;
          end else begin
`ifdef INV_KSCHED_SBOX_PIPE_EN
            // Words 1..3 are final now; word 0 completes in SUB.
            key_next   = {w0, w1n, w2n, w3n};
            sub_next   = sub_out;
            state_next = SUB;
`else
            key_next   = {w0 ^ sub_out ^ rcon(rnd), w1n, w2n, w3n};
            rnd_next   = rnd - 4'd1;
            state_next = EMIT;
`endif
          end
        end else begin
          state_next = EMIT;
        end
      end
`ifdef INV_KSCHED_SBOX_PIPE_EN
      SUB: begin
        key_next   = {w0 ^ sub_reg ^ rcon(rnd), key_reg[95:0]};
        rnd_next   = rnd - 4'd1;
        state_next = EMIT;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_reg  <= 128'h0;
      rnd      <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef INV_KSCHED_SBOX_PIPE_EN
      sub_reg  <= 32'h0;
`endif
    end else begin
      state    <= state_next;
      key_reg  <= key_next;
      rnd      <= rnd_next;
      rk_valid <= (state_next == EMIT);
      busy     <= (state_next == EMIT) || (state_next == SUB);
      done     <= (state_next == DONE);
`ifdef INV_KSCHED_SBOX_PIPE_EN
      sub_reg  <= sub_next;
`endif
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: vector table of cipher keys
// expanded by a forward key-expansion model, a scoreboard queue of expected
// round keys, and directed backpressure / start-while-busy / reset sequences.
module tb_aes_inv_key_schedule;
  import aes_pkg::*;

  typedef logic [10:0][127:0] ks_t;
  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;
  typedef struct {
    logic [127:0] key0;
    int           stall_at;
    int           stall_n;
    int           poke_at;
    bit           start_in_done;
    ks_t          exp;
    int           exp_lat;
  } vec_t;

`ifdef INV_KSCHED_SBOX_PIPE_EN
  localparam int BASE_LAT = 22;
`else
  localparam int BASE_LAT = 12;
`endif
  localparam int NVEC = 52;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready, rk_valid, busy, done;
  logic [127:0] last_key, round_key;
  logic [3:0]   rk_idx;

  int           n_chk = 0;
  int           n_pass = 0;
  exp_t         exp_q[$];
  logic [127:0] obs [16];
  vec_t         vec [NVEC];

  aes_inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
    .rk_ready(rk_ready), .rk_valid(rk_valid), .round_key(round_key),
    .rk_idx(rk_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [135:0] act, input logic [135:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
  endtask

  // Forward AES-128 key expansion; rcon generated by doubling in GF(2^8).
  function automatic ks_t fwd(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    ks_t         res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) res[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return res;
  endfunction

  // Scoreboard: every valid cycle is compared against the queue head;
  // the head is popped only on an actual handshake.
  always @(negedge clk) begin
    if (rst_n && rk_valid) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_key", {4'd0, rk_idx, round_key}, 136'h0);
      end else begin
        chk(round_key == exp_q[0].key && rk_idx == exp_q[0].idx,
            rk_ready ? "key_seq" : "key_hold",
            {4'd0, rk_idx, round_key}, {4'd0, exp_q[0].idx, exp_q[0].key});
        if (rk_ready) begin
          obs[rk_idx] = round_key;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int k, stalled;
    bit poked, bad_busy, got_done;
    for (int r = 10; r >= 0; r--) exp_q.push_back('{idx: 4'(r), key: v.exp[r]});
    @(posedge clk); #1;
    last_key = v.exp[10]; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stalled = 0; poked = 1'b0; bad_busy = 1'b0; got_done = 1'b0; k = 1;
    while (k < 80 && !got_done) begin
      rk_ready = 1'b1;
      if (rk_valid && rk_idx == 4'(v.stall_at) && stalled < v.stall_n) begin
        rk_ready = 1'b0;
        stalled++;
      end
      if (rk_valid && rk_idx == 4'(v.poke_at) && !poked) begin
        start = 1'b1; last_key = ~v.exp[10]; poked = 1'b1;
      end
      if (v.start_in_done && exp_q.size() == 0) begin
        start = 1'b1; last_key = ~v.exp[10];
      end
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!busy) bad_busy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k++;
      end
    end
    chk(got_done && k == v.exp_lat, "done_latency", 136'(k), 136'(v.exp_lat));
    chk(exp_q.size() == 0, "keys_outstanding", 136'(exp_q.size()), 136'h0);
    chk(!bad_busy, "busy_during_run", 136'(bad_busy), 136'h0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk(!done && !busy && !rk_valid, "idle_after_done", {133'h0, done, busy, rk_valid}, 136'h0);
    exp_q.delete();
  endtask

  initial begin
    int  k;
    bit  saw;
    logic [127:0] fips0;
    fips0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    for (int i = 0; i < NVEC; i++) begin
      vec[i].stall_at = -1; vec[i].stall_n = 0; vec[i].poke_at = -1;
      vec[i].start_in_done = 1'b0;
      if (i < 3)       vec[i].key0 = fips0;
      else if (i == 3) vec[i].key0 = 128'h0;
      else if (i == 4) vec[i].key0 = {128{1'b1}};
      else             vec[i].key0 = {$urandom, $urandom, $urandom, $urandom};
    end
    vec[0].start_in_done = 1'b1;
    vec[1].stall_at = 7; vec[1].stall_n = 3;
    vec[2].poke_at = 5;
    for (int i = 0; i < NVEC; i++) begin
      vec[i].exp     = fwd(vec[i].key0);
      vec[i].exp_lat = BASE_LAT + vec[i].stall_n;
    end

    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; last_key = 128'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(!rk_valid && !busy && !done && round_key == 128'h0 && rk_idx == 4'd0, "reset_state",
        {4'd0, rk_idx, round_key} | {133'h0, rk_valid, busy, done}, 136'h0);

    run_vec(vec[0]);
    chk(obs[10] == 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_idx10", 136'(obs[10]), 136'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk(obs[9]  == 128'hac7766f319fadc2128d12941575c006e, "fips_idx9",  136'(obs[9]),  136'(128'hac7766f319fadc2128d12941575c006e));
    chk(obs[1]  == 128'ha0fafe1788542cb123a339392a6c7605, "fips_idx1",  136'(obs[1]),  136'(128'ha0fafe1788542cb123a339392a6c7605));
    chk(obs[0]  == 128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_idx0",  136'(obs[0]),  136'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    for (int i = 1; i < NVEC; i++) run_vec(vec[i]);

    // Reset mid-run at idx4.
    for (int r = 10; r >= 0; r--) exp_q.push_back('{idx: 4'(r), key: vec[0].exp[r]});
    @(posedge clk); #1;
    last_key = vec[0].exp[10]; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(rk_valid && rk_idx == 4'd4) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(rk_valid && rk_idx == 4'd4, "reach_idx4", 136'(rk_idx), 136'd4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(!rk_valid && !busy && !done && round_key == 128'h0 && rk_idx == 4'd0, "reset_abort",
        {4'd0, rk_idx, round_key} | {133'h0, rk_valid, busy, done}, 136'h0);
    exp_q.delete();
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || rk_valid || busy) saw = 1'b1;
    end
    chk(!saw, "quiet_after_reset", 136'(saw), 136'h0);
    run_vec(vec[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Iterative AES-128 inverse key schedule. It takes the final round key (round 10) and regenerates the round keys in decryption order, 10 down to 0, emitting one 128-bit round key per handshake. It sits in front of the decryption datapath, so decryption needs no 1408-bit expanded-key store. It is the reverse-direction counterpart of the forward key expansion.

## Interface

Parameters: none.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge
- rst_n  in  1  — synchronous, active-low reset
- start  in  1  — request a new schedule run; accepted only while busy=0
- last_key  in  128  — round-10 key; word 0 is in [127:96]; sampled on the accepted start
- rk_ready  in  1  — consumer accepts the current round key
- rk_valid  out  1  — round_key and rk_idx are valid
- round_key  out  128  — current round key, same word/byte order as last_key
- rk_idx  out  4  — round number of round_key: 10 first, 0 last
- busy  out  1  — a run is in progress
- done  out  1  — single-cycle pulse after the round-0 key is accepted

## Operation

- States: IDLE, EMIT, SUB (SUB exists only with the pipeline macro), DONE.
- IDLE: busy=0, rk_valid=0.
  - start=1 loads key_reg←last_key and rnd←10, then moves to EMIT.
- EMIT: rk_valid=1, round_key=key_reg, rk_idx=rnd. Stay in EMIT while rk_ready=0; outputs are held stable.
- Handshake (rk_valid & rk_ready) with rnd=0: go to DONE.
- Handshake with rnd>0:
  - key_reg←inv_step(key_reg, rnd) and rnd←rnd−1.
  - Stay in EMIT, or go to SUB when the pipeline macro is defined.
- inv_step, with w0..w3 being key_reg words:
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
  - w0'=w0 ^ SubWord(RotWord(w3')) ^ Rcon(rnd)
  - RotWord is a left rotate by one byte.
  - Rcon(rnd) is {rc,24'h0}, with rc for 10..1 = 36,1b,80,40,20,10,08,04,02,01.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as done (DONE state) is ignored. The earliest accepted start is in the following IDLE cycle.
- rnd never wraps: the run ends at rnd=0, and no key is produced for round −1.

## Timing

- Reset (rst_n=0 at a clock edge) forces these values from the next cycle, regardless of state:
  - IDLE, rk_valid=0, busy=0, done=0
  - round_key=0, rk_idx=0
  - key_reg=0, rnd=0
- Reset mid-run aborts the run. No done pulse is produced and no partial keys are emitted after reset.
- start accepted at cycle T: rk_valid=1 with rk_idx=10 at T+1.
- Without the macro, rk_ready held high:
  - Keys 10..0 appear on T+1..T+11, one per cycle.
  - done=1 at T+12.
  - busy=1 on T+1..T+11.
- With the macro, rk_ready held high:
  - Key r appears at T+1+2·(10−r); round 0 is at T+21.
  - done=1 at T+22.
  - rk_valid=0 during SUB cycles.
- Backpressure adds exactly the stalled cycles; it does not change the key sequence.
- inv_step is one combinational stage: 4 S-box lookups plus XORs.

## Configuration

- INV_KSCHED_SBOX_PIPE_EN
  - Defined: SUB state registers SubWord(RotWord(w3')) and carries w1'..w3' forward. The key update completes on the SUB→EMIT edge, and each key after the first costs 2 cycles.
  - Undefined: single-cycle inv_step and no SUB state.
  - The output key sequence is identical in both builds.

## Structure

- aes_pkg holds:
  - the S-box function (the same table as the forward key expansion)
  - the Rcon function, keyed by round
  - the state encoding constants IDLE/EMIT/SUB/DONE
  - localparams NR=10 and KEY_W=128
- One sub-module: aes_subword. It is a 32-bit combinational SubWord built from four S-box lookups.
- The forward key expansion reuses aes_subword.

## Test plan

- FIPS-197 key: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1.
  - idx10 = last_key
  - idx9 = ac7766f319fadc2128d12941575c006e
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done at T+12 (T+22 with the macro)
- Backpressure: hold rk_ready=0 for 3 cycles at idx7.
  - round_key and rk_idx stay stable.
  - The sequence continues unchanged, and done is delayed by exactly 3 cycles.
- Start while busy: pulse start with a different last_key at idx5.
  - The pulse is ignored and the original sequence completes.
- Reset mid-run: drive rst_n=0 for one cycle at idx4.
  - Next cycle: all outputs are 0 and there is no done pulse.
  - A fresh start then yields the full 10..0 sequence.
- Round trip: drive random keys through the forward key expansion and feed its round-10 key in.
  - Each emitted key must equal the corresponding 128-bit slice of the forward expansion.
  - Cover 50 keys, including all-zero (idx0 = 0) and all-ones.
